// File: rtl/spi_flash_cmd_seq_if.sv
// Byte-transfer handshake between the flash command sequencer and the SPI byte engine.
// The sequencer is the master: it raises one request at a time and waits for done.
interface spi_flash_cmd_seq_if;
  logic       xfer_valid;
  logic       xfer_ready;
  logic [7:0] xfer_tx;
  logic       xfer_last;
  logic       xfer_done;
  logic [7:0] xfer_rx;

  modport master (
    output xfer_valid,
    output xfer_tx,
    output xfer_last,
    input  xfer_ready,
    input  xfer_done,
    input  xfer_rx
  );

  modport slave (
    input  xfer_valid,
    input  xfer_tx,
    input  xfer_last,
    output xfer_ready,
    output xfer_done,
    output xfer_rx
  );
endinterface

// File: rtl/spi_flash_cmd_seq.sv
// SPI NOR flash operation sequencer.
// Expands READ / PAGE PROGRAM / 64KB SECTOR ERASE / READ JEDEC ID into single-byte transfers
// on the byte engine: write-enable, command, 24-bit address, data, then WIP status polling.
// Optional feature macro: FLASH_SEQ_FAST_READ_EN selects FAST READ (0x0B) with one dummy byte.
module spi_flash_cmd_seq #(
  parameter int unsigned POLL_LIMIT = 65535
) (
  input  logic                       clk_i,
  input  logic                       rst_i,

  input  logic                       op_valid_i,
  output logic                       op_ready_o,
  input  logic [1:0]                 op_code_i,
  input  logic [23:0]                op_addr_i,
  input  logic [8:0]                 op_len_i,

  input  logic                       wdata_valid_i,
  input  logic [7:0]                 wdata_i,
  output logic                       wdata_ready_o,

  output logic                       rdata_valid_o,
  output logic [7:0]                 rdata_o,

  output logic                       done_o,
  output logic                       error_o,
  output logic                       busy_o,

  spi_flash_cmd_seq_if.master        xfer_io
);

  localparam logic [1:0] OpRead   = 2'd0;
  localparam logic [1:0] OpProg   = 2'd1;
  localparam logic [1:0] OpErase  = 2'd2;
  localparam logic [1:0] OpReadId = 2'd3;

  localparam logic [7:0] CmdWren   = 8'h06;
  localparam logic [7:0] CmdProg   = 8'h02;
  localparam logic [7:0] CmdErase  = 8'hD8;
  localparam logic [7:0] CmdReadId = 8'h9F;
  localparam logic [7:0] CmdRdsr   = 8'h05;

`ifdef FLASH_SEQ_FAST_READ_EN
  localparam logic [7:0] CmdRead = 8'h0B;
`else
  localparam logic [7:0] CmdRead = 8'h03;
`endif

  typedef enum logic [3:0] {
    StIdle,
    StCheck,
    StWren,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StPollCmd,
    StPollRd,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  cnt_q, cnt_d;     // data bytes still to transfer
  logic [1:0]  idx_q, idx_d;     // address byte index, MSB first
  logic [15:0] poll_q, poll_d;   // WIP-set status reads so far, saturating
  logic        sent_q, sent_d;   // current request accepted, waiting for xfer_done
  logic        have_q, have_d;   // program byte latched for the current transfer
  logic [7:0]  wbyte_q, wbyte_d;
  logic        err_q, err_d;
  logic        rvalid_q, rvalid_d;
  logic [7:0]  rdata_q, rdata_d;

  // Request checks, evaluated on the latched operation in StCheck
  logic        is_prog;
  logic        is_read_op;
  logic        len_bad;
  logic [9:0]  page_end;
  logic        reject;
  logic [16:0] poll_next;
  logic        poll_hit;

  assign is_prog    = (code_q == OpProg);
  assign is_read_op = (code_q == OpRead) || (code_q == OpReadId);
  assign len_bad    = (len_q == 9'd0) || (len_q > 9'd256);
  assign page_end   = {2'b00, addr_q[7:0]} + {1'b0, len_q};
  assign reject     = (((code_q == OpRead) || is_prog) && len_bad) ||
                      (is_prog && (page_end > 10'd256));
  assign poll_next  = {1'b0, poll_q} + 17'd1;
  assign poll_hit   = 32'(poll_next) >= POLL_LIMIT;

  // Next-state, datapath and output decode
  always_comb begin
    logic       xv;
    logic [7:0] xtx;
    logic       xlast;

    state_d  = state_q;
    code_d   = code_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    poll_d   = poll_q;
    sent_d   = sent_q;
    have_d   = have_q;
    wbyte_d  = wbyte_q;
    err_d    = err_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;

    xv            = 1'b0;
    xtx           = 8'h00;
    xlast         = 1'b0;
    op_ready_o    = (state_q == StIdle);
    busy_o        = (state_q != StIdle);
    done_o        = 1'b0;
    error_o       = 1'b0;
    wdata_ready_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (op_valid_i) begin
          code_d  = op_code_i;
          addr_d  = op_addr_i;
          len_d   = op_len_i;
          err_d   = 1'b0;
          sent_d  = 1'b0;
          have_d  = 1'b0;
          state_d = StCheck;
        end
      end

      StCheck: begin
        if (reject) begin
          err_d   = 1'b0 | 1'b1;
          state_d = StFinish;
        end else if (is_prog || (code_q == OpErase)) begin
          state_d = StWren;
        end else begin
          state_d = StCmd;
        end
      end

      StWren: begin
        xv    = !sent_q;
        xtx   = CmdWren;
        xlast = 1'b1;
        if (xfer_io.xfer_done) begin
          state_d = StCmd;
        end
      end

      StCmd: begin
        xv = !sent_q;
        unique case (code_q)
          OpRead:  xtx = CmdRead;
          OpProg:  xtx = CmdProg;
          OpErase: xtx = CmdErase;
          default: xtx = CmdReadId;
        endcase
        if (xfer_io.xfer_done) begin
          if (code_q == OpReadId) begin
            cnt_d   = 9'd3;
            state_d = StData;
          end else begin
            idx_d   = 2'd0;
            state_d = StAddr;
          end
        end
      end

      StAddr: begin
        xv = !sent_q;
        unique case (idx_q)
          2'd0:    xtx = addr_q[23:16];
          2'd1:    xtx = addr_q[15:8];
          default: xtx = addr_q[7:0];
        endcase
        xlast = (code_q == OpErase) && (idx_q == 2'd2);
        if (xfer_io.xfer_done) begin
          if (idx_q == 2'd2) begin
            cnt_d = len_q;
            if (code_q == OpErase) begin
              poll_d  = 16'd0;
              state_d = StPollCmd;
            end else begin
`ifdef FLASH_SEQ_FAST_READ_EN
              state_d = (code_q == OpRead) ? StDummy : StData;
`else
              state_d = StData;
`endif
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      StDummy: begin
        // Dummy rx byte is dropped: no rdata pulse
        xv = !sent_q;
        if (xfer_io.xfer_done) begin
          state_d = StData;
        end
      end

      StData: begin
        xlast = (cnt_q == 9'd1);
        if (is_prog) begin
          // Hold off the transfer until the requester supplies the byte; cs_n stays low
          wdata_ready_o = !have_q;
          if (wdata_valid_i && !have_q) begin
            have_d  = 1'b1;
            wbyte_d = wdata_i;
          end
          xv  = have_q && !sent_q;
          xtx = wbyte_q;
        end else begin
          xv = !sent_q;
        end
        if (xfer_io.xfer_done) begin
          cnt_d  = cnt_q - 9'd1;
          have_d = 1'b0;
          if (is_read_op) begin
            rvalid_d = 1'b1;
            rdata_d  = xfer_io.xfer_rx;
          end
          if (cnt_q == 9'd1) begin
            if (is_prog) begin
              poll_d  = 16'd0;
              state_d = StPollCmd;
            end else begin
              state_d = StFinish;
            end
          end
        end
      end

      StPollCmd: begin
        xv  = !sent_q;
        xtx = CmdRdsr;
        if (xfer_io.xfer_done) begin
          state_d = StPollRd;
        end
      end

      StPollRd: begin
        xv    = !sent_q;
        xlast = 1'b1;
        if (xfer_io.xfer_done) begin
          if (xfer_io.xfer_rx[0]) begin
            if (poll_hit) begin
              err_d   = 1'b1;
              state_d = StFinish;
            end else begin
              poll_d  = (poll_q == 16'hFFFF) ? poll_q : poll_next[15:0];
              state_d = StPollCmd;
            end
          end else begin
            state_d = StFinish;
          end
        end
      end

      StFinish: begin
        done_o  = 1'b1;
        error_o = err_q;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // One transfer outstanding: request drops after acceptance, rearms on done
    if (xv && xfer_io.xfer_ready) begin
      sent_d = 1'b1;
    end
    if (xfer_io.xfer_done) begin
      sent_d = 1'b0;
    end

    xfer_io.xfer_valid = xv;
    xfer_io.xfer_tx    = xtx;
    xfer_io.xfer_last  = xlast;
  end

  assign rdata_valid_o = rvalid_q;
  assign rdata_o       = rdata_q;

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      code_q   <= 2'd0;
      addr_q   <= 24'd0;
      len_q    <= 9'd0;
      cnt_q    <= 9'd0;
      idx_q    <= 2'd0;
      poll_q   <= 16'd0;
      sent_q   <= 1'b0;
      have_q   <= 1'b0;
      wbyte_q  <= 8'h00;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      poll_q   <= poll_d;
      sent_q   <= sent_d;
      have_q   <= have_d;
      wbyte_q  <= wbyte_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Self-checking bench for spi_flash_cmd_seq: table of operations, scoreboard queues for
// expected transfers / read bytes, a byte-engine model with random latencies.
module tb_spi_flash_cmd_seq;

  localparam int unsigned PollLim = 4;
`ifdef FLASH_SEQ_FAST_READ_EN
  localparam bit         Fast = 1'b1;
  localparam logic [7:0] RdOp = 8'h0B;
`else
  localparam bit         Fast = 1'b0;
  localparam logic [7:0] RdOp = 8'h03;
`endif

  logic        clk;
  logic        rst_i;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [1:0]  op_code_i;
  logic [23:0] op_addr_i;
  logic [8:0]  op_len_i;
  logic        wdata_valid_i;
  logic [7:0]  wdata_i;
  logic        wdata_ready_o;
  logic        rdata_valid_o;
  logic [7:0]  rdata_o;
  logic        done_o;
  logic        error_o;
  logic        busy_o;

  spi_flash_cmd_seq_if xfer ();

  spi_flash_cmd_seq #(.POLL_LIMIT(PollLim)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .op_valid_i    (op_valid_i),
    .op_ready_o    (op_ready_o),
    .op_code_i     (op_code_i),
    .op_addr_i     (op_addr_i),
    .op_len_i      (op_len_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_i       (wdata_i),
    .wdata_ready_o (wdata_ready_o),
    .rdata_valid_o (rdata_valid_o),
    .rdata_o       (rdata_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .busy_o        (busy_o),
    .xfer_io       (xfer)
  );

  typedef struct packed {
    logic [7:0] tx;
    logic       last;
  } xf_t;

  typedef struct {
    logic [1:0]  code;
    logic [23:0] addr;
    logic [8:0]  len;
    int          nwip;     // status reads returning WIP=1 before clear
    bit          rej;
    bit          gap;
    bit          exp_err;
  } op_rec_t;

  xf_t        exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] id_bytes[3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_err = 1'b0;
  int eng_done_cyc = 0;
  int wd_pops = 0;
  bit wd_gap = 1'b0;

  // engine model state
  int         est = 0;
  int         elat = 0;
  logic [7:0] ctx;
  logic       clast;
  xf_t        ecur;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Byte engine model: random accept and shift latency, pops expected transfers on accept
  initial begin
    xfer.xfer_ready = 1'b0;
    xfer.xfer_done  = 1'b0;
    xfer.xfer_rx    = 8'h00;
    forever begin
      @(negedge clk);
      xfer.xfer_done = 1'b0;
      if (rst_i) begin
        est = 0;
        xfer.xfer_ready = 1'b0;
      end else begin
        case (est)
          0: if (xfer.xfer_valid) begin
            ctx  = xfer.xfer_tx;
            clast = xfer.xfer_last;
            elat = int'($urandom_range(0, 2));
            if (elat == 0) begin
              xfer.xfer_ready = 1'b1;
              est = 2;
            end else begin
              est = 1;
            end
          end
          1: begin
            check("req held", {31'd0, xfer.xfer_valid}, 32'd1);
            check("tx stable", {24'd0, xfer.xfer_tx}, {24'd0, ctx});
            check("last stable", {31'd0, xfer.xfer_last}, {31'd0, clast});
            elat--;
            if (elat == 0) begin
              xfer.xfer_ready = 1'b1;
              est = 2;
            end
          end
          2: begin
            xfer.xfer_ready = 1'b0;
            check("valid drop", {31'd0, xfer.xfer_valid}, 32'd0);
            if (exp_q.size() == 0) begin
              fail_now($sformatf("unexpected xfer tx=0x%0h", ctx));
            end else begin
              ecur = exp_q.pop_front();
              check("xfer tx", {24'd0, ctx}, {24'd0, ecur.tx});
              check("xfer last", {31'd0, clast}, {31'd0, ecur.last});
            end
            elat = int'($urandom_range(0, 3));
            est = 3;
          end
          default: begin
            check("one outstanding", {31'd0, xfer.xfer_valid}, 32'd0);
            if (elat == 0) begin
              xfer.xfer_done = 1'b1;
              xfer.xfer_rx   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
              eng_done_cyc   = cyc;
              est = 0;
            end else begin
              elat--;
            end
          end
        endcase
      end
    end
  end

  // Program data source; handshake decided at negedge since wdata_ready_o is register-based
  initial begin
    bit hs;
    wdata_valid_i = 1'b0;
    wdata_i       = 8'h00;
    forever begin
      @(negedge clk);
      wdata_valid_i = (wd_q.size() > 0) && !wd_gap;
      wdata_i       = (wd_q.size() > 0) ? wd_q[0] : 8'h00;
      hs = wdata_valid_i && wdata_ready_o && !rst_i;
      @(posedge clk);
      if (hs && wd_q.size() > 0) begin
        void'(wd_q.pop_front());
        wd_pops++;
      end
    end
  end

  // Read data and completion monitors
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rdata_valid_o) begin
        if (rd_q.size() == 0) begin
          fail_now($sformatf("unexpected rdata 0x%0h", rdata_o));
        end else begin
          e = rd_q.pop_front();
          check("rdata", {24'd0, rdata_o}, {24'd0, e});
        end
      end
      if (done_o) begin
        done_cnt++;
        done_err = error_o;
        done_cyc = cyc;
      end
    end
  end

  task automatic push(input logic [7:0] tx, input logic last, input logic [7:0] rx);
    xf_t e;
    e.tx   = tx;
    e.last = last;
    exp_q.push_back(e);
    rx_q.push_back(rx);
  endtask

  // Expand an operation into the transfer sequence the flash protocol requires
  task automatic build(input op_rec_t r);
    logic [7:0] op;
    logic [7:0] b;
    int n;
    int reads;
    if (r.rej) return;
    if (r.code == 2'd1 || r.code == 2'd2) push(8'h06, 1'b1, 8'hFF);
    case (r.code)
      2'd0:    op = RdOp;
      2'd1:    op = 8'h02;
      2'd2:    op = 8'hD8;
      default: op = 8'h9F;
    endcase
    push(op, 1'b0, 8'hFF);
    if (r.code != 2'd3) begin
      for (int i = 0; i < 3; i++) begin
        b = 8'(r.addr >> (16 - 8 * i));
        push(b, (r.code == 2'd2) && (i == 2), 8'hFF);
      end
    end
    if (Fast && r.code == 2'd0) push(8'h00, 1'b0, 8'h5A);
    if (r.code != 2'd2) begin
      n = (r.code == 2'd3) ? 3 : int'(r.len);
      for (int i = 0; i < n; i++) begin
        if (r.code == 2'd1) begin
          b = 8'(i);
          wd_q.push_back(b);
          push(b, i == n - 1, 8'hFF);
        end else begin
          b = (r.code == 2'd3) ? id_bytes[i] : (8'(i * 29 + 7) ^ r.addr[7:0]);
          push(8'h00, i == n - 1, b);
          rd_q.push_back(b);
        end
      end
    end
    if (r.code == 2'd1 || r.code == 2'd2) begin
      reads = (r.nwip >= int'(PollLim)) ? int'(PollLim) : r.nwip + 1;
      for (int p = 0; p < reads; p++) begin
        push(8'h05, 1'b0, 8'hFF);
        push(8'h00, 1'b1, (p < r.nwip) ? 8'h01 : 8'h00);
      end
    end
  endtask

  task automatic start_op(input op_rec_t r, input string nm);
    @(negedge clk);
    check({nm, " ready"}, {31'd0, op_ready_o}, 32'd1);
    op_valid_i = 1'b1;
    op_code_i  = r.code;
    op_addr_i  = r.addr;
    op_len_i   = r.len;
    @(negedge clk);
    op_valid_i = 1'b0;
    check({nm, " busy"}, {31'd0, busy_o}, 32'd1);
    check({nm, " not ready"}, {31'd0, op_ready_o}, 32'd0);
    check({nm, " no early xfer"}, {31'd0, xfer.xfer_valid}, 32'd0);
  endtask

  task automatic run_op(input op_rec_t r, input string nm);
    int d0;
    int t;
    wd_gap = r.gap;
    build(r);
    d0 = done_cnt;
    start_op(r, nm);
    @(negedge clk);
    if (r.rej) begin
      check({nm, " reject done"}, {31'd0, done_o}, 32'd1);
      check({nm, " reject err"}, {31'd0, error_o}, 32'd1);
      check({nm, " reject no xfer"}, {31'd0, xfer.xfer_valid}, 32'd0);
    end else begin
      check({nm, " first xfer lat"}, {31'd0, xfer.xfer_valid}, 32'd1);
    end
    if (r.gap) begin
      t = 0;
      while (!wdata_ready_o && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) fail_now({nm, " wdata_ready timeout"});
      for (int g = 0; g < 5; g++) begin
        @(negedge clk);
        check({nm, " gap no xfer"}, {31'd0, xfer.xfer_valid}, 32'd0);
        check({nm, " gap wready"}, {31'd0, wdata_ready_o}, 32'd1);
      end
      wd_gap = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) fail_now({nm, " done timeout"});
    repeat (3) @(negedge clk);
    check({nm, " done count"}, done_cnt, d0 + 1);
    check({nm, " error"}, {31'd0, done_err}, {31'd0, r.exp_err});
    if (!r.rej) check({nm, " done lat"}, done_cyc - eng_done_cyc, 32'd1);
    check({nm, " xfers left"}, exp_q.size(), 32'd0);
    check({nm, " rdata left"}, rd_q.size(), 32'd0);
    check({nm, " wdata left"}, wd_q.size(), 32'd0);
    exp_q.delete();
    rx_q.delete();
    rd_q.delete();
    wd_q.delete();
  endtask

  op_rec_t tbl[10];
  op_rec_t rr;

  initial begin
    int t;
    int d0;
    int p0;
    id_bytes[0] = 8'h20;
    id_bytes[1] = 8'hBA;
    id_bytes[2] = 8'h19;
    //            code   addr        len     nwip rej gap err
    tbl[0] = '{2'd3, 24'h000000, 9'd0,   0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'd0, 24'h000100, 9'd4,   0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{2'd1, 24'h0000F0, 9'd16,  2, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{2'd1, 24'h0000F8, 9'd16,  0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{2'd0, 24'h000000, 9'd0,   0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{2'd2, 24'h123456, 9'd0,   4, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{2'd0, 24'h000200, 9'd257, 0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{2'd1, 24'h012300, 9'd256, 0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{2'd2, 24'hABCDEF, 9'd0,   1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{2'd0, 24'h00FFFF, 9'd256, 0, 1'b0, 1'b0, 1'b0};

    rst_i      = 1'b1;
    op_valid_i = 1'b0;
    op_code_i  = 2'd0;
    op_addr_i  = 24'd0;
    op_len_i   = 9'd0;
    repeat (3) @(negedge clk);
    check("rst op_ready", {31'd0, op_ready_o}, 32'd1);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst done", {31'd0, done_o}, 32'd0);
    check("rst error", {31'd0, error_o}, 32'd0);
    check("rst rvalid", {31'd0, rdata_valid_o}, 32'd0);
    check("rst rdata", {24'd0, rdata_o}, 32'd0);
    check("rst wready", {31'd0, wdata_ready_o}, 32'd0);
    check("rst xvalid", {31'd0, xfer.xfer_valid}, 32'd0);
    check("rst xtx", {24'd0, xfer.xfer_tx}, 32'd0);
    check("rst xlast", {31'd0, xfer.xfer_last}, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i], $sformatf("row%0d", i));
    end

    // Reset in the middle of a PROGRAM data phase
    rr = '{2'd1, 24'h000040, 9'd8, 0, 1'b0, 1'b0, 1'b0};
    wd_gap = 1'b0;
    build(rr);
    p0 = wd_pops;
    start_op(rr, "rstmid");
    t = 0;
    while (wd_pops < p0 + 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now("rstmid data phase timeout");
    d0 = done_cnt;
    rst_i = 1'b1;
    @(negedge clk);
    check("rstmid op_ready", {31'd0, op_ready_o}, 32'd1);
    check("rstmid busy", {31'd0, busy_o}, 32'd0);
    check("rstmid xvalid", {31'd0, xfer.xfer_valid}, 32'd0);
    check("rstmid wready", {31'd0, wdata_ready_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete();
    rx_q.delete();
    rd_q.delete();
    wd_q.delete();
    repeat (5) @(negedge clk);
    check("rstmid no done", done_cnt, d0);

    run_op(tbl[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_cmd_seq.md
# spi_flash_cmd_seq

- Sequences SPI NOR flash operations for the SPI master datapath.
- Accepts one high-level operation at a time from a requester: READ, PAGE PROGRAM, 64KB SECTOR ERASE or READ JEDEC ID.
- Expands each operation into byte transfers on the byte engine that drives sclk/cs_n/MOSI/MISO: write-enable, command, 24-bit address, data, then status polling until the device clears WIP.

## Interface
- `POLL_LIMIT`, default 65535: maximum status reads after PROGRAM/ERASE before timeout error.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `op_valid_i` in 1: operation request.
- `op_ready_o` out 1: high only in IDLE.
- `op_code_i` in 2: 0 READ, 1 PROGRAM, 2 ERASE, 3 READ_ID.
- `op_addr_i` in 24: flash byte address.
- `op_len_i` in 9: byte count, 1..256; ignored for ERASE/READ_ID.
- `wdata_valid_i` in 1: program data byte available.
- `wdata_i` in 8: program data byte.
- `wdata_ready_o` out 1: program byte consumed on valid&ready.
- `rdata_valid_o` out 1: one-cycle pulse per read byte.
- `rdata_o` out 8: read byte.
- `done_o` out 1: one-cycle pulse at operation end.
- `error_o` out 1: valid with done_o; 1 = rejected or timed out.
- `busy_o` out 1: state != IDLE.
- `xfer_valid_o` out 1: byte transfer request to engine.
- `xfer_ready_i` in 1: engine accepts request.
- `xfer_tx_o` out 8: byte to shift out.
- `xfer_last_o` out 1: engine raises cs_n after this byte.
- `xfer_done_i` in 1: one-cycle pulse, byte fully shifted.
- `xfer_rx_i` in 8: byte shifted in, valid with xfer_done_i.

## Operation
- States: IDLE, CHECK, WREN, CMD, ADDR, DUMMY, DATA, POLL_CMD, POLL_RD, FINISH.
- IDLE: accept on op_valid_i&op_ready_o; latch code/addr/len; go CHECK.
- CHECK rejects, with no SPI traffic and done_o+error_o in FINISH:
  - READ/PROGRAM with len 0 or >256.
  - PROGRAM with addr[7:0]+len > 256 (page crossing).
- WREN: PROGRAM/ERASE only; single transfer 0x06, last=1.
- CMD opcodes:
  - READ 0x03.
  - PROGRAM 0x02.
  - ERASE 0xD8.
  - READ_ID 0x9F.
  - CMD is always last=0.
- ADDR: 3 bytes, addr[23:16], [15:8], [7:0]. ERASE sets last=1 on the third byte, then goes to POLL_CMD.
- DATA:
  - READ: len transfers of tx 0x00.
  - READ_ID: 3 transfers of tx 0x00.
  - Read ops: each xfer_done_i pulses rdata_valid_o with rdata_o=xfer_rx_i.
  - PROGRAM: wdata_ready_o=1 while waiting for a byte; the consumed byte is sent as the next transfer.
  - Final data byte has last=1.
- After DATA: READ/READ_ID go to FINISH; PROGRAM goes to POLL_CMD.
- POLL_CMD: send 0x05 with last=0. POLL_RD: send 0x00 with last=1.
  - rx bit0=1: increment poll count and repeat POLL_CMD.
  - rx bit0=0: FINISH with error_o=0.
  - Poll count reaching POLL_LIMIT with WIP still set: FINISH with error_o=1.
- FINISH: pulse done_o for one cycle, return to IDLE.
- Widths:
  - Internal byte counter is 9 bits, counting len down to 0.
  - Poll counter is 16 bits, saturating.
  - Address is not incremented by this block; the device auto-increments.

## Timing
- Reset values:
  - op_ready_o=1.
  - All other outputs 0, including xfer_tx_o=0x00.
  - State IDLE; counters cleared.
- Reset mid-operation: return to IDLE next cycle. The byte engine shares rst_i and releases cs_n itself. No done_o is generated.
- Exactly one transfer outstanding:
  - xfer_valid_o/xfer_tx_o/xfer_last_o stay stable until xfer_ready_i.
  - xfer_valid_o drops the cycle after acceptance.
  - The next request is not raised before xfer_done_i.
- Latency:
  - Accept to first xfer_valid_o: 2 cycles (IDLE→CHECK→WREN/CMD).
  - xfer_done_i to next xfer_valid_o: 1 cycle.
  - Last xfer_done_i to done_o: 1 cycle.
- rdata_valid_o is asserted in the cycle after xfer_done_i. There is no backpressure; the requester must sink every byte.
- PROGRAM stall: with wdata_valid_i low, the state holds and no transfer is issued; cs_n stays low.
- op_valid_i while busy is ignored (op_ready_o=0).

## Configuration
- `FLASH_SEQ_FAST_READ_EN` defined:
  - READ uses opcode 0x0B.
  - One DUMMY transfer of tx 0x00, last=0, is inserted between ADDR and DATA.
  - The dummy rx byte is discarded and produces no rdata_valid_o.
- Undefined: READ uses 0x03, the DUMMY state is never entered, and address bytes go directly to data bytes.

## Test plan
- READ_ID, engine model returns 0x20,0xBA,0x19 → transfers 0x9F,00,00,00(last); rdata 0x20,0xBA,0x19; done_o, error_o=0.
- READ addr 0x000100 len 4 → transfers 0x03,00,01,00,00×4 with last on 4th data; 4 rdata pulses; done_o. With `FLASH_SEQ_FAST_READ_EN`: 0x0B plus one extra 0x00 dummy, still 4 rdata pulses.
- PROGRAM addr 0x0000F0 len 16, data 0x00..0x0F, status returns 0x01,0x01,0x00 → 0x06(last), 0x02,00,00,F0, 16 data (last on 16th), three 0x05/0x00 poll pairs; done_o, error_o=0. wdata_valid_i gapped for 5 cycles → no transfer issued during the gap.
- PROGRAM addr 0x0000F8 len 16, and READ len 0 → no xfer_valid_o; done_o+error_o 2 cycles after accept.
- ERASE with POLL_LIMIT=4, status stuck 0x01 → 0x06, 0xD8+3 addr (last), 4 poll pairs, done_o+error_o=1.
- rst_i asserted mid-PROGRAM data phase → next cycle IDLE, op_ready_o=1, xfer_valid_o=0, no done_o; a following READ_ID completes normally.
